// File: rtl/if_pc_select_if.sv
// Fetch-stage PC-select bundle: branch controls and targets toward the PC stage,
// selected next PC, taken flag and registered PC back out.
interface if_pc_select_if #(
  parameter int unsigned AW = 16
);
  logic [1:0]    BS;
  logic          PS;
  logic          Z;
  logic [AW-1:0] BrA;
  logic [AW-1:0] RAA;
  logic [AW-1:0] PC1;
  logic          stall;
  logic [AW-1:0] next_pc;
  logic          taken;
  logic [AW-1:0] PC;

  modport master (
    output BS, PS, Z, BrA, RAA, PC1, stall,
    input  next_pc, taken, PC
  );

  modport slave (
    input  BS, PS, Z, BrA, RAA, PC1, stall,
    output next_pc, taken, PC
  );
endinterface

// File: rtl/if_pc_select.sv
// Instruction-fetch PC stage: picks PC+1 / branch / register jump / jump and registers it.
// Optional taken-branch counter enabled by defining IF_BRANCH_COUNT_EN.
module if_pc_select #(
  parameter int unsigned   AW       = 16,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  if_pc_select_if.slave   bus
`ifdef IF_BRANCH_COUNT_EN
  ,
  output logic [15:0]     taken_cnt
`endif
);

  logic          w_cond;
  logic [AW-1:0] w_next_pc;
  logic          w_taken;
  logic [AW-1:0] r_pc;

  assign w_cond = bus.Z ^ bus.PS;

  // Unknown or 00 selects fall through to the sequential address.
  always_comb begin
    w_next_pc = bus.PC1;
    w_taken   = 1'b0;
    case (bus.BS)
      2'b01: begin
        if (w_cond) begin
          w_next_pc = bus.BrA;
          w_taken   = 1'b1;
        end
      end
      2'b10: begin
        w_next_pc = bus.RAA;
        w_taken   = 1'b1;
      end
      2'b11: begin
        w_next_pc = bus.BrA;
        w_taken   = 1'b1;
      end
      default: begin
        w_next_pc = bus.PC1;
        w_taken   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (!bus.stall) begin
      r_pc <= w_next_pc;
    end
  end

  assign bus.next_pc = w_next_pc;
  assign bus.taken   = w_taken;
  assign bus.PC      = r_pc;

`ifdef IF_BRANCH_COUNT_EN
  logic [15:0] r_taken_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_taken_cnt <= '0;
    end else if (!bus.stall && w_taken && (r_taken_cnt != '1)) begin
      r_taken_cnt <= r_taken_cnt + 16'd1;
    end
  end

  assign taken_cnt = r_taken_cnt;
`endif

endmodule

// File: tb/tb_if_pc_select.sv
// Self-checking bench for if_pc_select: directed scenarios plus randomized stimulus vs a reference model.
module tb_if_pc_select;

  localparam int unsigned AW = 16;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [AW-1:0] exp_pc;
  logic [15:0]   exp_cnt;

  if_pc_select_if #(.AW(AW)) bus ();

`ifdef IF_BRANCH_COUNT_EN
  logic [15:0] taken_cnt;
`endif

  if_pc_select #(
    .AW(AW),
    .RESET_PC(16'h0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
`ifdef IF_BRANCH_COUNT_EN
    ,
    .taken_cnt(taken_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: pick which source the rules name, then return that value.
  // Result bit AW is the taken flag.
  function automatic logic [AW:0] model(input logic [1:0] bs, input logic ps, input logic z,
                                        input logic [AW-1:0] bra, input logic [AW-1:0] raa,
                                        input logic [AW-1:0] pc1);
    int src; // 0 = sequential, 1 = branch target, 2 = register target
    if (bs === 2'd3) src = 1;
    else if (bs === 2'd2) src = 2;
    else if (bs === 2'd1 && (z != ps)) src = 1;
    else src = 0;
    if (src == 1) return {1'b1, bra};
    if (src == 2) return {1'b1, raa};
    return {1'b0, pc1};
  endfunction

  task automatic drive(input logic [1:0] bs, input logic ps, input logic z,
                       input logic [AW-1:0] bra, input logic [AW-1:0] raa,
                       input logic [AW-1:0] pc1, input logic st);
    bus.BS    = bs;
    bus.PS    = ps;
    bus.Z     = z;
    bus.BrA   = bra;
    bus.RAA   = raa;
    bus.PC1   = pc1;
    bus.stall = st;
  endtask

  // Advance one clock and update expected state from the inputs that were applied.
  task automatic tick();
    logic [AW:0] m;
    m = model(bus.BS, bus.PS, bus.Z, bus.BrA, bus.RAA, bus.PC1);
    @(posedge clk);
    if (rst) begin
      exp_pc  = 16'h0000;
      exp_cnt = 16'h0000;
    end else if (!bus.stall) begin
      exp_pc = m[AW-1:0];
      if (m[AW] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(2'b11, 1'b0, 1'b0, 16'h0FF0, 16'h0000, 16'h0001, 1'b0);
    tick();
    tick();
    total++;
    if (bus.PC !== 16'h0000) begin
      bad++;
      $display("FAIL reset_hold: PC=%h expected=%h", bus.PC, 16'h0000);
    end
    total++;
    if (bus.next_pc !== 16'h0FF0 || bus.taken !== 1'b1) begin
      bad++;
      $display("FAIL reset_comb: next_pc=%h taken=%b expected=%h/1", bus.next_pc, bus.taken, 16'h0FF0);
    end
    rst = 1'b0;
    tick();
    total++;
    if (bus.PC !== 16'h0FF0) begin
      bad++;
      $display("FAIL reset_release_load: PC=%h expected=%h", bus.PC, 16'h0FF0);
    end
    // Asynchronous assertion mid-cycle with PC = 0FF0.
    #2 rst = 1'b1;
    #1;
    total++;
    if (bus.PC !== 16'h0000) begin
      bad++;
      $display("FAIL reset_async: PC=%h expected=%h", bus.PC, 16'h0000);
    end
`ifdef IF_BRANCH_COUNT_EN
    total++;
    if (taken_cnt !== 16'h0000) begin
      bad++;
      $display("FAIL reset_cnt: taken_cnt=%h expected=%h", taken_cnt, 16'h0000);
    end
`endif
    exp_pc  = 16'h0000;
    exp_cnt = 16'h0000;
    drive(2'b11, 1'b0, 1'b0, 16'h0FF0, 16'h0000, 16'h0001, 1'b1);
    tick();
    total++;
    if (bus.PC !== 16'h0000) begin
      bad++;
      $display("FAIL reset_over_stall: PC=%h expected=%h", bus.PC, 16'h0000);
    end
    rst = 1'b0;
    drive(2'b00, 1'b0, 1'b0, 16'h0FF0, 16'h0000, 16'h0001, 1'b0);
    tick();
    total++;
    if (bus.PC !== 16'h0001) begin
      bad++;
      $display("FAIL reset_then_inc: PC=%h expected=%h", bus.PC, 16'h0001);
    end
  endtask

  task automatic test_uncond_jump();
    drive(2'b11, 1'b0, 1'b0, 16'h0FF0, 16'h0000, 16'h0001, 1'b0);
    #1;
    total++;
    if (bus.next_pc !== 16'h0FF0 || bus.taken !== 1'b1) begin
      bad++;
      $display("FAIL jump_comb: next_pc=%h taken=%b expected=%h/1", bus.next_pc, bus.taken, 16'h0FF0);
    end
    tick();
    total++;
    if (bus.PC !== 16'h0FF0) begin
      bad++;
      $display("FAIL jump_pc: PC=%h expected=%h", bus.PC, 16'h0FF0);
    end
  endtask

  task automatic test_reg_jump_inc();
    drive(2'b10, 1'b0, 1'b0, 16'h0FF0, 16'hF00F, 16'h0001, 1'b0);
    #1;
    total++;
    if (bus.taken !== 1'b1) begin
      bad++;
      $display("FAIL regjump_taken: taken=%b expected=1", bus.taken);
    end
    tick();
    total++;
    if (bus.PC !== 16'hF00F) begin
      bad++;
      $display("FAIL regjump_pc: PC=%h expected=%h", bus.PC, 16'hF00F);
    end
    drive(2'b00, 1'b0, 1'b0, 16'h0FF0, 16'hF00F, 16'h0002, 1'b0);
    #1;
    total++;
    if (bus.taken !== 1'b0) begin
      bad++;
      $display("FAIL inc_taken: taken=%b expected=0", bus.taken);
    end
    tick();
    total++;
    if (bus.PC !== 16'h0002) begin
      bad++;
      $display("FAIL inc_pc: PC=%h expected=%h", bus.PC, 16'h0002);
    end
  endtask

  task automatic test_cond_branch();
    logic [1:0]    pz [4];
    logic [AW-1:0] want_pc [4];
    logic          want_tk [4];
    pz[0] = 2'b10; want_pc[0] = 16'h0FF0; want_tk[0] = 1'b1;
    pz[1] = 2'b11; want_pc[1] = 16'h0004; want_tk[1] = 1'b0;
    pz[2] = 2'b01; want_pc[2] = 16'h0FF0; want_tk[2] = 1'b1;
    pz[3] = 2'b00; want_pc[3] = 16'h0004; want_tk[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(2'b01, pz[i][1], pz[i][0], 16'h0FF0, 16'hAAAA, 16'h0004, 1'b0);
      #1;
      total++;
      if (bus.next_pc !== want_pc[i] || bus.taken !== want_tk[i]) begin
        bad++;
        $display("FAIL cond_comb PS=%b Z=%b: next_pc=%h taken=%b expected=%h/%b",
                 pz[i][1], pz[i][0], bus.next_pc, bus.taken, want_pc[i], want_tk[i]);
      end
      tick();
      total++;
      if (bus.PC !== want_pc[i]) begin
        bad++;
        $display("FAIL cond_pc PS=%b Z=%b: PC=%h expected=%h", pz[i][1], pz[i][0], bus.PC, want_pc[i]);
      end
    end
  endtask

  task automatic test_stall();
    drive(2'b11, 1'b0, 1'b0, 16'h0FF0, 16'h0000, 16'h0001, 1'b0);
    tick();
    drive(2'b11, 1'b0, 1'b0, 16'h1234, 16'h0000, 16'h0001, 1'b1);
    #1;
    total++;
    if (bus.next_pc !== 16'h1234) begin
      bad++;
      $display("FAIL stall_comb: next_pc=%h expected=%h", bus.next_pc, 16'h1234);
    end
    tick();
    tick();
    total++;
    if (bus.PC !== 16'h0FF0) begin
      bad++;
      $display("FAIL stall_hold: PC=%h expected=%h", bus.PC, 16'h0FF0);
    end
    bus.stall = 1'b0;
    tick();
    total++;
    if (bus.PC !== 16'h1234) begin
      bad++;
      $display("FAIL stall_release: PC=%h expected=%h", bus.PC, 16'h1234);
    end
  endtask

  task automatic test_boundary();
    drive(2'b10, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 16'h0000, 1'b0);
    tick();
    total++;
    if (bus.PC !== 16'hFFFF) begin
      bad++;
      $display("FAIL all_ones: PC=%h expected=%h", bus.PC, 16'hFFFF);
    end
    drive(2'bxx, 1'b0, 1'b0, 16'h0FF0, 16'hF00F, 16'h5555, 1'b0);
    #1;
    total++;
    if (bus.next_pc !== 16'h5555 || bus.taken !== 1'b0) begin
      bad++;
      $display("FAIL bs_unknown: next_pc=%h taken=%b expected=%h/0", bus.next_pc, bus.taken, 16'h5555);
    end
    drive(2'b00, 1'b0, 1'b0, 16'h0FF0, 16'hF00F, 16'h5555, 1'b0);
    tick();
  endtask

  task automatic test_random();
    logic [AW:0] m;
    for (int i = 0; i < 400; i++) begin
      drive(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
            16'($urandom), ($urandom_range(0, 3) == 0));
      m = model(bus.BS, bus.PS, bus.Z, bus.BrA, bus.RAA, bus.PC1);
      #1;
      total++;
      if (bus.next_pc !== m[AW-1:0] || bus.taken !== m[AW]) begin
        bad++;
        $display("FAIL rand_comb[%0d]: next_pc=%h taken=%b expected=%h/%b",
                 i, bus.next_pc, bus.taken, m[AW-1:0], m[AW]);
      end
      tick();
      total++;
      if (bus.PC !== exp_pc) begin
        bad++;
        $display("FAIL rand_pc[%0d]: PC=%h expected=%h", i, bus.PC, exp_pc);
      end
`ifdef IF_BRANCH_COUNT_EN
      total++;
      if (taken_cnt !== exp_cnt) begin
        bad++;
        $display("FAIL rand_cnt[%0d]: taken_cnt=%h expected=%h", i, taken_cnt, exp_cnt);
      end
`endif
    end
  endtask

`ifdef IF_BRANCH_COUNT_EN
  task automatic test_branch_count();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 1 || i == 3) drive(2'b00, 1'b0, 1'b0, 16'h0FF0, 16'h0000, 16'h0001, 1'b0);
      else drive(2'b11, 1'b0, 1'b0, 16'h0FF0, 16'h0000, 16'h0001, 1'b0);
      tick();
    end
    total++;
    if (taken_cnt !== 16'd3) begin
      bad++;
      $display("FAIL cnt_three: taken_cnt=%h expected=%h", taken_cnt, 16'd3);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(2'b11, 1'b0, 1'b0, 16'h0FF0, 16'h0000, 16'h0001, 1'b0);
    for (int i = 0; i < 65537; i++) tick();
    total++;
    if (taken_cnt !== 16'hFFFF) begin
      bad++;
      $display("FAIL cnt_saturate: taken_cnt=%h expected=%h", taken_cnt, 16'hFFFF);
    end
    rst = 1'b1;
    #1;
    total++;
    if (taken_cnt !== 16'h0000) begin
      bad++;
      $display("FAIL cnt_reset: taken_cnt=%h expected=%h", taken_cnt, 16'h0000);
    end
    tick();
    rst = 1'b0;
  endtask
`endif

  initial begin
    total   = 0;
    bad     = 0;
    exp_pc  = 16'h0000;
    exp_cnt = 16'h0000;
    rst     = 1'b1;
    drive(2'b00, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    test_reset();
    test_uncond_jump();
    test_reg_jump_inc();
    test_cond_branch();
    test_stall();
    test_boundary();
    test_random();
`ifdef IF_BRANCH_COUNT_EN
    test_branch_count();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
